// File: rtl/ex_stage_mdu_pkg.sv
// Shared constants for the RV32IM execute stage.
//   - MDU funct3 operation codes
//   - MDU state encodings (plain 2-bit constants so they can be compared in
//     legacy code and bound to checkers directly)
//   - ALU/shift opcodes and instruction format codes used by the EX stage
//   - default datapath width
package ex_stage_mdu_pkg;

    localparam int XLEN_DEFAULT = 32;

    // RV32M funct3 codes
    localparam logic [2:0] MDU_MUL    = 3'd0;
    localparam logic [2:0] MDU_MULH   = 3'd1;
    localparam logic [2:0] MDU_MULHSU = 3'd2;
    localparam logic [2:0] MDU_MULHU  = 3'd3;
    localparam logic [2:0] MDU_DIV    = 3'd4;
    localparam logic [2:0] MDU_DIVU   = 3'd5;
    localparam logic [2:0] MDU_REM    = 3'd6;
    localparam logic [2:0] MDU_REMU   = 3'd7;

    // MDU state encodings
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // ALU opcodes (ALUorSHIFT = 0)
    localparam logic [4:0] ALU_ADD   = 5'd0;
    localparam logic [4:0] ALU_SUB   = 5'd1;
    localparam logic [4:0] ALU_AND   = 5'd2;
    localparam logic [4:0] ALU_OR    = 5'd3;
    localparam logic [4:0] ALU_XOR   = 5'd4;
    localparam logic [4:0] ALU_SLT   = 5'd5;
    localparam logic [4:0] ALU_SLTU  = 5'd6;
    localparam logic [4:0] ALU_EQ    = 5'd7;
    localparam logic [4:0] ALU_NE    = 5'd8;
    localparam logic [4:0] ALU_GE    = 5'd9;
    localparam logic [4:0] ALU_GEU   = 5'd10;
    localparam logic [4:0] ALU_PASSB = 5'd11;
    localparam logic [4:0] ALU_PACK  = 5'd12;
    // Shift opcodes (ALUorSHIFT = 1)
    localparam logic [4:0] ALU_SLL   = 5'd13;
    localparam logic [4:0] ALU_SRL   = 5'd14;
    localparam logic [4:0] ALU_SRA   = 5'd15;

    // Instruction formats
    localparam logic [2:0] FT_R = 3'd0;
    localparam logic [2:0] FT_I = 3'd1;
    localparam logic [2:0] FT_S = 3'd2;
    localparam logic [2:0] FT_B = 3'd3;
    localparam logic [2:0] FT_U = 3'd4;
    localparam logic [2:0] FT_J = 3'd5;

endpackage

// File: rtl/ex_stage_mdu_iter.sv
// mdu_iter: multi-cycle RV32M multiply/divide engine.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   start             issue request (only honoured in ST_IDLE)
//   flush             abort any operation in flight
//   op, a, b          funct3 and operands, sampled on the issue edge only
//   busy              front end must hold (issue cycle and MUL/DIV cycles)
//   done              result valid this cycle (ST_DONE, not flushed)
//   result            MDU result, meaningful while done = 1
//   state_o           current FSM state for observation
module mdu_iter
    import ex_stage_mdu_pkg::*;
#(
    parameter int XLEN     = XLEN_DEFAULT,
    parameter int MUL_LAT  = 2,
    parameter int DIV_FAST = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [1:0]      state_o
);
    localparam int CNT_MAX = (XLEN > MUL_LAT) ? XLEN : MUL_LAT;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]      state_q, state_d;
    logic [2:0]      op_q, op_d;
    logic [XLEN-1:0] a_q, a_d, b_q, b_d;
    logic [XLEN-1:0] quo_q, quo_d, rem_q, rem_d, res_q, res_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            a_sgn_q, a_sgn_d, b_sgn_q, b_sgn_d;
    logic            quo_neg_q, quo_neg_d, rem_neg_q, rem_neg_d;
    logic            div0_q, div0_d;

    // Issue-time decode of the incoming divide operands
    logic            div_signed, neg_a, neg_b, div0_in, ovf_in;
    logic [XLEN-1:0] abs_a, abs_b;
    assign div_signed = ~op[0];                 // DIV and REM are even codes
    assign neg_a      = div_signed & a[XLEN-1];
    assign neg_b      = div_signed & b[XLEN-1];
    assign abs_a      = neg_a ? -a : a;
    assign abs_b      = neg_b ? -b : b;
    assign div0_in    = (b == '0);
    assign ovf_in     = div_signed & (a == MIN_NEG) & (b == '1);

    // Multiplier works on the captured operands, sign-extended to 2*XLEN so
    // one unsigned multiply covers the signed, mixed and unsigned variants.
    logic [2*XLEN-1:0] mul_a, mul_b, prod;
    logic [XLEN-1:0]   mul_res;
    assign mul_a   = {{XLEN{a_sgn_q & a_q[XLEN-1]}}, a_q};
    assign mul_b   = {{XLEN{b_sgn_q & b_q[XLEN-1]}}, b_q};
    assign prod    = mul_a * mul_b;
    assign mul_res = (op_q == MDU_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

    // One restoring-division step on magnitudes: quo_q shifts the dividend
    // out from the top while quotient bits shift in at the bottom.
    logic [XLEN:0]   div_shift;
    logic            div_ge;
    logic [XLEN-1:0] rem_step, quo_step, quo_fix, rem_fix;
    assign div_shift = {rem_q, quo_q[XLEN-1]};
    assign div_ge    = (div_shift >= {1'b0, b_q});
    assign rem_step  = div_ge ? XLEN'(div_shift - {1'b0, b_q}) : div_shift[XLEN-1:0];
    assign quo_step  = {quo_q[XLEN-2:0], div_ge};
    // Divide by zero keeps the all-ones quotient unsigned; the remainder
    // magnitude is |a| there, so the normal fix-up restores the dividend.
    assign quo_fix   = div0_q ? '1 : (quo_neg_q ? -quo_step : quo_step);
    assign rem_fix   = rem_neg_q ? -rem_step : rem_step;

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        res_d     = res_q;
        cnt_d     = cnt_q;
        a_sgn_d   = a_sgn_q;
        b_sgn_d   = b_sgn_q;
        quo_neg_d = quo_neg_q;
        rem_neg_d = rem_neg_q;
        div0_d    = div0_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d    = op;
                    a_d     = a;
                    b_d     = b;
                    cnt_d   = '0;
                    a_sgn_d = (op == MDU_MULH) || (op == MDU_MULHSU);
                    b_sgn_d = (op == MDU_MULH);
                    if (!op[2]) begin
                        state_d = (MUL_LAT == 1) ? ST_DONE : ST_MUL;
                    end else begin
                        b_d       = abs_b;
                        quo_d     = abs_a;
                        rem_d     = '0;
                        quo_neg_d = neg_a ^ neg_b;
                        rem_neg_d = neg_a;
                        div0_d    = div0_in;
                        if ((DIV_FAST != 0) && (div0_in || ovf_in)) begin
                            state_d = ST_DONE;
                            if (div0_in) res_d = op[1] ? a : '1;
                            else         res_d = op[1] ? '0 : MIN_NEG;
                        end else begin
                            state_d = ST_DIV;
                        end
                    end
                end
            end
            ST_MUL: begin
                if (cnt_q == CW'(MUL_LAT - 2)) state_d = ST_DONE;
                else                           cnt_d   = cnt_q + 1'b1;
            end
            ST_DIV: begin
                rem_d = rem_step;
                quo_d = quo_step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(XLEN - 1)) begin
                    state_d = ST_DONE;
                    res_d   = op_q[1] ? rem_fix : quo_fix;
                end
            end
            default: state_d = ST_IDLE;       // ST_DONE lasts one cycle
        endcase
        if (flush && (state_q != ST_IDLE)) state_d = ST_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            res_q     <= '0;
            cnt_q     <= '0;
            a_sgn_q   <= 1'b0;
            b_sgn_q   <= 1'b0;
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            div0_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            res_q     <= res_d;
            cnt_q     <= cnt_d;
            a_sgn_q   <= a_sgn_d;
            b_sgn_q   <= b_sgn_d;
            quo_neg_q <= quo_neg_d;
            rem_neg_q <= rem_neg_d;
            div0_q    <= div0_d;
        end
    end

    assign busy    = ((state_q == ST_IDLE) && start) ||
                     (((state_q == ST_MUL) || (state_q == ST_DIV)) && !flush);
    assign done    = (state_q == ST_DONE) && !flush;
    assign result  = op_q[2] ? res_q : mul_res;
    assign state_o = state_q;

endmodule

// File: rtl/ex_stage_mdu.sv
// ex_stage_mdu: RV32IM execute stage between ID/EX and EX/MEM.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   *_DE                       ID/EX register contents
//   FLUSH_E                    kill the EX instruction (and any MDU op)
//   ForwardA/B, ALU_VAL_EM,
//   RD_VAL_WB                  operand forwarding
//   ALU_VAL_E, STORE_VAL_E     result and forwarded rs2
//   PC_IMM_E, isBranch_E       redirect target and taken flag
//   VALID_E, STALL_E           completion / front-end hold
//   MDU_STATE_E                MDU FSM state for observation
// Handshake: STALL_E = 1 means ID/EX is not consumed this cycle (PC, IF/ID
// and ID/EX hold, EX/MEM loads a bubble). VALID_E = 1 means ALU_VAL_E is a
// completed result that EX/MEM captures this cycle. They are never both 1.
module ex_stage_mdu
    import ex_stage_mdu_pkg::*;
#(
    parameter int XLEN     = XLEN_DEFAULT,
    parameter int MUL_LAT  = 2,
    parameter int DIV_FAST = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            VALID_DE,
    input  logic            FLUSH_E,
    input  logic [XLEN-1:0] PC_DE,
    input  logic            ALUSrc_DE,
    input  logic            Branch_DE,
    input  logic            ALUorSHIFT_DE,
    input  logic            RS1_PC_DE,
    input  logic            RS1_Z_DE,
    input  logic [4:0]      ALUOp_DE,
    input  logic [2:0]      FT_DE,
    input  logic [1:0]      PACK_SIZE_DE,
    input  logic            IS_MDU_DE,
    input  logic [2:0]      MDU_OP_DE,
    input  logic [XLEN-1:0] RF_DATA1_DE,
    input  logic [XLEN-1:0] RF_DATA2_DE,
    input  logic [XLEN-1:0] IMM_VAL_EXT_DE,
    input  logic [1:0]      ForwardA,
    input  logic [1:0]      ForwardB,
    input  logic [XLEN-1:0] ALU_VAL_EM,
    input  logic [XLEN-1:0] RD_VAL_WB,
    output logic [XLEN-1:0] ALU_VAL_E,
    output logic [XLEN-1:0] STORE_VAL_E,
    output logic [XLEN-1:0] PC_IMM_E,
    output logic            isBranch_E,
    output logic            VALID_E,
    output logic            STALL_E,
    output logic [1:0]      MDU_STATE_E
);
    logic [XLEN-1:0] fwd_a, fwd_b, op_a, op_b, alu_res, sh_res, alu_out;
    logic [XLEN-1:0] pack_res, jalr_sum, mdu_result;
    logic [4:0]      shamt;
    logic            mdu_start, mdu_busy, mdu_done;

    always_comb begin
        case (ForwardA)
            2'b10:   fwd_a = ALU_VAL_EM;
            2'b01:   fwd_a = RD_VAL_WB;
            default: fwd_a = RF_DATA1_DE;
        endcase
        case (ForwardB)
            2'b10:   fwd_b = ALU_VAL_EM;
            2'b01:   fwd_b = RD_VAL_WB;
            default: fwd_b = RF_DATA2_DE;
        endcase
        if (RS1_PC_DE)     op_a = PC_DE;
        else if (RS1_Z_DE) op_a = '0;
        else               op_a = fwd_a;
        op_b = ALUSrc_DE ? IMM_VAL_EXT_DE : fwd_b;
    end

    assign shamt = op_b[4:0];

    // Pack the low byte/half of each operand side by side, zero-extended
    always_comb begin
        case (PACK_SIZE_DE)
            2'b00:   pack_res = XLEN'(op_a[7:0]) | (XLEN'(op_b[7:0]) << 8);
            2'b01:   pack_res = XLEN'(op_a[XLEN/2-1:0]) | (XLEN'(op_b[XLEN/2-1:0]) << (XLEN/2));
            default: pack_res = op_a;
        endcase
    end

    always_comb begin
        case (ALUOp_DE)
            ALU_ADD:   alu_res = op_a + op_b;
            ALU_SUB:   alu_res = op_a - op_b;
            ALU_AND:   alu_res = op_a & op_b;
            ALU_OR:    alu_res = op_a | op_b;
            ALU_XOR:   alu_res = op_a ^ op_b;
            ALU_SLT:   alu_res = XLEN'($signed(op_a) < $signed(op_b));
            ALU_SLTU:  alu_res = XLEN'(op_a < op_b);
            ALU_EQ:    alu_res = XLEN'(op_a == op_b);
            ALU_NE:    alu_res = XLEN'(op_a != op_b);
            ALU_GE:    alu_res = XLEN'($signed(op_a) >= $signed(op_b));
            ALU_GEU:   alu_res = XLEN'(op_a >= op_b);
            ALU_PASSB: alu_res = op_b;
            ALU_PACK:  alu_res = pack_res;
            default:   alu_res = '0;
        endcase
        case (ALUOp_DE)
            ALU_SLL: sh_res = op_a << shamt;
            ALU_SRL: sh_res = op_a >> shamt;
            ALU_SRA: sh_res = $signed(op_a) >>> shamt;
            default: sh_res = op_a;
        endcase
        alu_out = ALUorSHIFT_DE ? sh_res : alu_res;
    end

    // JALR is the only branch-class instruction in I format
    assign jalr_sum    = fwd_a + IMM_VAL_EXT_DE;
    assign PC_IMM_E    = (Branch_DE && (FT_DE == FT_I)) ? {jalr_sum[XLEN-1:1], 1'b0}
                                                        : PC_DE + IMM_VAL_EXT_DE;
    assign isBranch_E  = Branch_DE & VALID_DE & ~((FT_DE == FT_B) & ~alu_res[0]);
    assign STORE_VAL_E = fwd_b;

    // rst_n gates issue so the stall drops as soon as reset asserts, even
    // while ID/EX still presents an MDU instruction.
    assign mdu_start = IS_MDU_DE & VALID_DE & ~FLUSH_E & rst_n;

    mdu_iter #(
        .XLEN     (XLEN),
        .MUL_LAT  (MUL_LAT),
        .DIV_FAST (DIV_FAST)
    ) u_mdu_iter (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mdu_start),
        .flush   (FLUSH_E),
        .op      (MDU_OP_DE),
        .a       (fwd_a),
        .b       (fwd_b),
        .busy    (mdu_busy),
        .done    (mdu_done),
        .result  (mdu_result),
        .state_o (MDU_STATE_E)
    );

    // An MDU instruction in ID/EX only completes through the DONE cycle
    assign ALU_VAL_E = mdu_done ? mdu_result : alu_out;
    assign VALID_E   = mdu_done | (VALID_DE & ~IS_MDU_DE);
    assign STALL_E   = mdu_busy;

endmodule

// File: tb/tb_ex_stage_mdu.sv
module tb_ex_stage_mdu;
    import ex_stage_mdu_pkg::*;

    localparam int W       = 32;
    localparam int MUL_LAT = 2;
    localparam int DIV_LAT = W + 1;

    logic         clk, rst_n;
    logic         VALID_DE, FLUSH_E, ALUSrc_DE, Branch_DE, ALUorSHIFT_DE;
    logic         RS1_PC_DE, RS1_Z_DE, IS_MDU_DE;
    logic [W-1:0] PC_DE, RF_DATA1_DE, RF_DATA2_DE, IMM_VAL_EXT_DE;
    logic [W-1:0] ALU_VAL_EM, RD_VAL_WB;
    logic [4:0]   ALUOp_DE;
    logic [2:0]   FT_DE, MDU_OP_DE;
    logic [1:0]   PACK_SIZE_DE, ForwardA, ForwardB, MDU_STATE_E;
    logic [W-1:0] ALU_VAL_E, STORE_VAL_E, PC_IMM_E;
    logic         isBranch_E, VALID_E, STALL_E;

    ex_stage_mdu #(.XLEN(W), .MUL_LAT(MUL_LAT), .DIV_FAST(1)) dut (
        .clk(clk), .rst_n(rst_n), .VALID_DE(VALID_DE), .FLUSH_E(FLUSH_E),
        .PC_DE(PC_DE), .ALUSrc_DE(ALUSrc_DE), .Branch_DE(Branch_DE),
        .ALUorSHIFT_DE(ALUorSHIFT_DE), .RS1_PC_DE(RS1_PC_DE), .RS1_Z_DE(RS1_Z_DE),
        .ALUOp_DE(ALUOp_DE), .FT_DE(FT_DE), .PACK_SIZE_DE(PACK_SIZE_DE),
        .IS_MDU_DE(IS_MDU_DE), .MDU_OP_DE(MDU_OP_DE),
        .RF_DATA1_DE(RF_DATA1_DE), .RF_DATA2_DE(RF_DATA2_DE),
        .IMM_VAL_EXT_DE(IMM_VAL_EXT_DE), .ForwardA(ForwardA), .ForwardB(ForwardB),
        .ALU_VAL_EM(ALU_VAL_EM), .RD_VAL_WB(RD_VAL_WB), .ALU_VAL_E(ALU_VAL_E),
        .STORE_VAL_E(STORE_VAL_E), .PC_IMM_E(PC_IMM_E), .isBranch_E(isBranch_E),
        .VALID_E(VALID_E), .STALL_E(STALL_E), .MDU_STATE_E(MDU_STATE_E)
    );

    // ---------------- clock / reset / cycle counter ----------------
    int cyc = 0;
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int           exp_cyc_q[$];
    int           n_checks = 0;
    int           n_pass   = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        else n_pass++;
    endtask

    task automatic expect_result(input logic [W-1:0] val, input int lat);
        exp_q.push_back(val);
        exp_cyc_q.push_back(cyc + lat);
    endtask

    // monitor: every VALID_E pulse must match the next expected result and cycle
    initial begin
        logic [W-1:0] e;
        int           c;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && VALID_E === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_valid: got result 0x%08h with nothing expected (cycle %0d)", ALU_VAL_E, cyc);
                end else begin
                    e = exp_q.pop_front();
                    c = exp_cyc_q.pop_front();
                    check("result", ALU_VAL_E, e);
                    check("valid_cycle", W'(cyc), W'(c));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic clear_inputs();
        VALID_DE = 0; FLUSH_E = 0; ALUSrc_DE = 0; Branch_DE = 0; ALUorSHIFT_DE = 0;
        RS1_PC_DE = 0; RS1_Z_DE = 0; IS_MDU_DE = 0; MDU_OP_DE = '0;
        PC_DE = '0; RF_DATA1_DE = '0; RF_DATA2_DE = '0; IMM_VAL_EXT_DE = '0;
        ALU_VAL_EM = '0; RD_VAL_WB = '0; ALUOp_DE = ALU_ADD; FT_DE = FT_R;
        PACK_SIZE_DE = '0; ForwardA = 2'b00; ForwardB = 2'b00;
    endtask

    // operands arrive through the forwarding paths: a from EX/MEM, b from MEM/WB
    task automatic set_mdu(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        clear_inputs();
        VALID_DE = 1; IS_MDU_DE = 1; MDU_OP_DE = op;
        ForwardA = 2'b10; ALU_VAL_EM = a;
        ForwardB = 2'b01; RD_VAL_WB = b;
        RF_DATA1_DE = $urandom; RF_DATA2_DE = $urandom;
    endtask

    task automatic scramble_fwd();
        ALU_VAL_EM = $urandom; RD_VAL_WB = $urandom;
        RF_DATA1_DE = $urandom; RF_DATA2_DE = $urandom;
        ForwardA = 2'($urandom_range(0, 3)); ForwardB = 2'($urandom_range(0, 3));
    endtask

    task automatic run_mdu(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] exp, input int lat);
        @(posedge clk); #1;
        set_mdu(op, a, b);
        expect_result(exp, lat);
        for (int k = 0; k <= lat; k++) begin
            if (k > 0) begin @(posedge clk); #1; scramble_fwd(); end
            @(negedge clk);
            check("stall", W'(STALL_E), W'(k < lat));
        end
        @(posedge clk); #1;
        clear_inputs();
    endtask

    // single-cycle instruction: fields already set, result same cycle
    task automatic alu_issue(input logic [W-1:0] exp);
        VALID_DE = 1;
        expect_result(exp, 0);
        @(negedge clk);
        check("alu_stall", W'(STALL_E), '0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        clear_inputs();
        rst_n = 0;
        repeat (3) @(negedge clk);
        check("rst_stall", W'(STALL_E), '0);
        check("rst_valid", W'(VALID_E), '0);
        check("rst_state", W'(MDU_STATE_E), W'(ST_IDLE));
        rst_n = 1;

        // ADD with rs1 forwarded from EX/MEM: 5 + 7
        @(posedge clk); #1; clear_inputs();
        ForwardA = 2'b10; ALU_VAL_EM = 32'd5; RF_DATA2_DE = 32'd7;
        alu_issue(32'd12);

        // SUB with rs2 forwarded from MEM/WB: 100 - 30, store value is forwarded rs2
        @(posedge clk); #1; clear_inputs();
        ALUOp_DE = ALU_SUB; RF_DATA1_DE = 32'd100; ForwardB = 2'b01; RD_VAL_WB = 32'd30;
        alu_issue(32'd70);
        check("store_val", STORE_VAL_E, 32'd30);

        // SRAI 0xF0000000 >> 4
        @(posedge clk); #1; clear_inputs();
        ALUOp_DE = ALU_SRA; ALUorSHIFT_DE = 1; ALUSrc_DE = 1;
        RF_DATA1_DE = 32'hF000_0000; IMM_VAL_EXT_DE = 32'd4;
        alu_issue(32'hFF00_0000);

        // BEQ taken: 9 == 9, target PC + imm
        @(posedge clk); #1; clear_inputs();
        ALUOp_DE = ALU_EQ; FT_DE = FT_B; Branch_DE = 1; PC_DE = 32'h100;
        IMM_VAL_EXT_DE = 32'h20; RF_DATA1_DE = 32'd9; RF_DATA2_DE = 32'd9;
        alu_issue(32'd1);
        check("beq_taken", W'(isBranch_E), 32'd1);
        check("beq_target", PC_IMM_E, 32'h120);

        // BNE not taken with equal operands
        @(posedge clk); #1;
        ALUOp_DE = ALU_NE;
        alu_issue(32'd0);
        check("bne_not_taken", W'(isBranch_E), 32'd0);

        // JALR: target is (rs1 + imm) with LSB cleared
        @(posedge clk); #1; clear_inputs();
        FT_DE = FT_I; Branch_DE = 1; ALUSrc_DE = 1;
        RF_DATA1_DE = 32'h1001; IMM_VAL_EXT_DE = 32'd4;
        alu_issue(32'h1005);
        check("jalr_taken", W'(isBranch_E), 32'd1);
        check("jalr_target", PC_IMM_E, 32'h1004);

        // multiplies
        run_mdu(MDU_MULH,   32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, MUL_LAT);
        run_mdu(MDU_MULHU,  32'hFFFF_FFFF, 32'd2, 32'h0000_0001, MUL_LAT);
        run_mdu(MDU_MULHSU, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, MUL_LAT);
        run_mdu(MDU_MUL,    32'h0001_0003, 32'h0000_0010, 32'h0010_0030, MUL_LAT);

        // full-length divides
        run_mdu(MDU_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, DIV_LAT);
        run_mdu(MDU_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, DIV_LAT);
        run_mdu(MDU_DIVU, 32'd100, 32'd7, 32'd14, DIV_LAT);
        run_mdu(MDU_REMU, 32'd100, 32'd7, 32'd2,  DIV_LAT);

        // divide-by-zero and overflow finish early
        run_mdu(MDU_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        run_mdu(MDU_REMU, 32'd5, 32'd0, 32'd5, 1);
        run_mdu(MDU_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_mdu(MDU_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);

        // flush at issue+10 of a DIV: stall drops at once, no result
        @(posedge clk); #1;
        set_mdu(MDU_DIV, 32'd1000, 32'd3);
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            if (k == 10) FLUSH_E = 1;
            @(negedge clk);
            check("flush_stall", W'(STALL_E), W'(k < 10));
        end
        check("flush_valid", W'(VALID_E), '0);
        @(posedge clk); #1;
        clear_inputs();
        @(negedge clk);
        check("flush_state", W'(MDU_STATE_E), W'(ST_IDLE));

        // ADD 3 + 4 right after the flush
        @(posedge clk); #1; clear_inputs();
        RF_DATA1_DE = 32'd3; ALUSrc_DE = 1; IMM_VAL_EXT_DE = 32'd4;
        alu_issue(32'd7);
        @(posedge clk); #1; clear_inputs();

        // reset at issue+5 of a DIV while ID/EX still holds it
        @(posedge clk); #1;
        set_mdu(MDU_DIV, 32'd1000, 32'd3);
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("pre_rst_stall", W'(STALL_E), 32'd1);
        end
        @(posedge clk); #1;
        rst_n = 0;
        #1;
        check("mid_rst_stall", W'(STALL_E), '0);
        check("mid_rst_state", W'(MDU_STATE_E), W'(ST_IDLE));
        check("mid_rst_valid", W'(VALID_E), '0);
        @(posedge clk); #1;
        clear_inputs();
        @(negedge clk);
        rst_n = 1;
        run_mdu(MDU_MUL, 32'd6, 32'd7, 32'd42, MUL_LAT);

        // drain: nothing may remain outstanding
        repeat (5) @(negedge clk);
        check("queue_empty", W'(exp_q.size()), '0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
